uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised RS232/UART serial receiver; next generation of the fixed 8N1 receiver.
//  Adds configurable bit time, data width, parity and stop bits, plus a 3-sample majority vote.
//  Provides a valid/ready output holding register and framing/parity/overrun flags.
//  Sits between the board RX pin (asynchronous) and the byte-consumer logic in the clk_s domain.
// PARAMETERS
//  CLKS_PER_BIT  6  clk_s cycles per serial bit; must be >=4.
//  DATA_BITS     8  payload bits per frame, range 5..9, sent LSB first.
//  PARITY        0  0=none, 1=odd, 2=even.
//  STOP_BITS     1  1 or 2.
//  SYNC_STAGES   2  input synchroniser depth, >=2.
// PORTS
//  clk_s   in   1          sole clock.
//  rstn_s  in   1          synchronous, active-low reset (rstn_s=0 resets on the clk_s edge).
//  iDATA   in   1          asynchronous serial line, idles high.
//  oDATA   out  DATA_BITS  received payload, valid while oVALID=1.
//  oVALID  out  1          frame held in the output register.
//  iREADY  in   1          consumer accepts; handshake occurs when oVALID&iREADY.
//  oDONE   out  1          1-cycle pulse per completed frame, whether or not it was stored.
//  oPERR   out  1          parity error for the held frame.
//  oFERR   out  1          framing error (a stop bit sampled 0) for the held frame.
//  oOVR    out  1          sticky: a frame was dropped because oVALID was still 1; cleared on handshake.
//  oBUSY   out  1          FSM not in IDLE.
// BEHAVIOUR
//  - Reset values: oDATA=0, oVALID=0, oDONE=0, oPERR=0, oFERR=0, oOVR=0, oBUSY=0; FSM=IDLE;
//    synchroniser flops reset to 1.
//  - Synchroniser: all decisions use rx_s, the SYNC_STAGES-flop copy of iDATA.
//  - Sampling: bit counter runs 0..CLKS_PER_BIT-1; M=CLKS_PER_BIT/2 (integer divide).
//    The bit value is the majority of rx_s at counts M-1, M, M+1, decided at count M+1.
//  - FSM states: IDLE, START, DATA, PAR, STOP, BRK.
//    IDLE: rx_s==0 -> START, counter=0.
//    START: at the vote, result 1 = false start -> IDLE with no output, no oDONE;
//      result 0 -> continue; leave at count CLKS_PER_BIT-1.
//    DATA: DATA_BITS bits shifted in LSB first -> PAR if PARITY!=0, else STOP.
//    PAR: received bit compared with the computed bit.
//      Odd: XOR of data^parity must equal 1. Even: that XOR must equal 0.
//    STOP: STOP_BITS bits; any stop vote of 0 sets ferr.
//      Commit on the cycle after the last stop-bit vote, without waiting for the bit end.
//      Then go to IDLE, or to BRK if ferr=1.
//    BRK: wait until rx_s==1, then IDLE. A held-low (break) line yields exactly one frame.
//  - Commit cycle: oDONE=1 for that cycle only.
//    If oVALID==0, or oVALID&iREADY in the same cycle: load oDATA/oPERR/oFERR and set oVALID=1.
//    Otherwise keep the old data and set oOVR=1; the new frame is lost.
//  - Handshake without commit: oVALID<=0, oOVR<=0. oDATA and error flags hold their last value.
//  - Latency: oVALID rises SYNC_STAGES + 1 cycles after the last stop-bit vote point on iDATA.
//  - Reset mid-frame: abandon the frame immediately with no oDONE. Receive resumes once
//    rx_s is seen high then low.
//  - Widths: bit counter is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(DATA_BITS+1) bits.
//    No wrap beyond terminal counts.
// STRUCTURE
//  - Package uart_pkg: parity-mode constants (PAR_NONE/ODD/EVEN) and the rx state enum.
//    Shared with a future uart_tx_cfg.
//  - Sub-module sync_bit (SYNC_STAGES flops, reset value parameter) for iDATA.
//    Everything else stays in one module.
// TESTING (CLKS_PER_BIT=6, bit period 12 ns at 2 ns clk_s unless noted)
//  1. 8N1, send 0xA5 with iREADY=1 -> oDATA=0xA5, one oDONE pulse, oVALID for 1 cycle,
//     oPERR=oFERR=oOVR=0.
//  2. PARITY=2, DATA_BITS=7: send 0x37 with parity 1 -> oPERR=0; same data with parity 0 -> oPERR=1.
//  3. 2-cycle low glitch on idle iDATA -> no oDONE, oBUSY returns to 0 within 6 cycles.
//  4. 0x55 with stop bit 0, then line held low 60 cycles -> oFERR=1, exactly one oDONE.
//     A subsequent 0x3C frame is received clean.
//  5. iREADY=0; send 0x11 then 0x22 -> oDATA=0x11, oOVR=1, two oDONE pulses.
//     Pulse iREADY -> oVALID=0, oOVR=0.
//  6. Assert rstn_s=0 for 3 cycles during data bit 4 -> all outputs at reset values.
//     Next frame 0xF0 -> oDATA=0xF0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions for the rx/tx pair: parity modes, receiver states, vote helper.
// Pure declarations; no latency, no flow control.
// Backpressure: not applicable.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        RX_BRK
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous bit, reset to a chosen value.
// Latency: STAGES clk_s cycles.
// Backpressure: none, free-running.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_s,
    input  logic rstn_s,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            ff_q <= {STAGES{RST_VAL}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority vote and a one-deep valid/ready output register.
// Latency: oVALID rises SYNC_STAGES+1 cycles after the last stop-bit vote point on iDATA.
// Backpressure: a frame finishing while oVALID is still held is dropped and flagged on oOVR.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 6,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk_s,
    input  logic                 rstn_s,
    input  logic                 iDATA,
    output logic [DATA_BITS-1:0] oDATA,
    output logic                 oVALID,
    input  logic                 iREADY,
    output logic                 oDONE,
    output logic                 oPERR,
    output logic                 oFERR,
    output logic                 oOVR,
    output logic                 oBUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int M  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_V0   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(M);
    localparam logic [CW-1:0] CNT_V2   = CW'(M + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                 armed_q;
    logic                 vote;
    logic                 par_x;
    logic                 at_vote;
    logic                 at_end;
    logic                 commit;

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_s  (clk_s),
        .rstn_s (rstn_s),
        .d      (iDATA),
        .q      (rx_s)
    );

    assign vote    = maj3(samp_q[0], samp_q[1], rx_s);
    assign par_x   = (^data_q) ^ vote;
    assign at_vote = (cnt_q == CNT_V2);
    assign at_end  = (cnt_q == CNT_LAST);
    assign oBUSY   = (state_q != RX_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        samp_d  = samp_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        commit  = 1'b0;

        if (state_q != RX_IDLE && state_q != RX_BRK) begin
            cnt_d = at_end ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_V0) samp_d[0] = rx_s;
            if (cnt_q == CNT_V1) samp_d[1] = rx_s;
        end

        case (state_q)
            RX_IDLE: begin
                // The reset value of the synchroniser is not a real idle level, hence armed_q.
                if (armed_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (at_vote && vote) begin
                    state_d = RX_IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (at_vote) data_d = {vote, data_q[DATA_BITS-1:1]};
                if (at_end) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RX_PAR: begin
                if (at_vote) begin
                    perr_d = (PARITY == PAR_EVEN) ? par_x :
                             (PARITY == PAR_ODD)  ? ~par_x : 1'b0;
                end
                if (at_end) state_d = RX_STOP;
            end
            RX_STOP: begin
                if (at_vote) begin
                    ferr_d = ferr_q | ~vote;
                    // Commit straight off the final vote; the rest of the stop bit is not waited for.
                    if (stop_q == STOP_LAST) begin
                        commit  = 1'b1;
                        cnt_d   = '0;
                        state_d = (ferr_q | ~vote) ? RX_BRK : RX_IDLE;
                    end
                end
                if (at_end && !commit) stop_d = 1'b1;
            end
            RX_BRK: begin
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            samp_q  <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            samp_q  <= samp_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & rx_s);
        end
    end

    always_ff @(posedge clk_s) begin
        if (!rstn_s) begin
            oDATA  <= '0;
            oVALID <= 1'b0;
            oDONE  <= 1'b0;
            oPERR  <= 1'b0;
            oFERR  <= 1'b0;
            oOVR   <= 1'b0;
        end else begin
            oDONE <= commit;
            if (commit) begin
                if (!oVALID || iREADY) begin
                    oDATA  <= data_q;
                    oPERR  <= perr_q;
                    oFERR  <= ferr_d;
                    oVALID <= 1'b1;
                    oOVR   <= 1'b0;
                end else begin
                    oOVR <= 1'b1;
                end
            end else if (oVALID && iREADY) begin
                oVALID <= 1'b0;
                oOVR   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance, table vectors, corner sequences, random frames.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int CPB = 6;

    logic       clk = 1'b0;
    logic       rstn_a, rstn_b, line_a, line_b, rdy_a, rdy_b;
    logic [7:0] a_data;
    logic [6:0] b_data;
    logic       a_valid, a_done, a_perr, a_ferr, a_ovr, a_busy;
    logic       b_valid, b_done, b_perr, b_ferr, b_ovr, b_busy;

    int errors = 0;
    int checks = 0;
    int done_a = 0, done_b = 0, vcyc_a = 0, vcyc_b = 0;
    logic [10:0] obs_a[$];
    logic [10:0] obs_b[$];

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE),
                  .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
        .clk_s(clk), .rstn_s(rstn_a), .iDATA(line_a), .oDATA(a_data), .oVALID(a_valid),
        .iREADY(rdy_a), .oDONE(a_done), .oPERR(a_perr), .oFERR(a_ferr), .oOVR(a_ovr), .oBUSY(a_busy));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN),
                  .STOP_BITS(2), .SYNC_STAGES(2)) dut_b (
        .clk_s(clk), .rstn_s(rstn_b), .iDATA(line_b), .oDATA(b_data), .oVALID(b_valid),
        .iREADY(rdy_b), .oDONE(b_done), .oPERR(b_perr), .oFERR(b_ferr), .oOVR(b_ovr), .oBUSY(b_busy));

    always #1 clk = ~clk;

    // Observes each cycle mid-low-phase: handshakes, done pulses, valid cycles.
    always begin
        @(negedge clk);
        #0.5;
        if (a_done === 1'b1) done_a++;
        if (b_done === 1'b1) done_b++;
        if (a_valid === 1'b1) vcyc_a++;
        if (b_valid === 1'b1) vcyc_b++;
        if (a_valid === 1'b1 && rdy_a === 1'b1 && rstn_a === 1'b1) obs_a.push_back({1'b0, a_data, a_perr, a_ferr});
        if (b_valid === 1'b1 && rdy_b === 1'b1 && rstn_b === 1'b1) obs_b.push_back({2'b00, b_data, b_perr, b_ferr});
    end

    typedef struct packed {
        logic [8:0] d;
        logic v, p, f, o, b, dn;
    } snap_t;

    typedef struct {
        int         sel;
        logic [8:0] d;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] exp_d;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    function automatic snap_t snap(input int sel);
        snap_t s;
        if (sel == 0) s = '{{1'b0, a_data}, a_valid, a_perr, a_ferr, a_ovr, a_busy, a_done};
        else          s = '{{2'b00, b_data}, b_valid, b_perr, b_ferr, b_ovr, b_busy, b_done};
        return s;
    endfunction

    function automatic int done_of(input int sel);
        return (sel == 0) ? done_a : done_b;
    endfunction

    function automatic int vcyc_of(input int sel);
        return (sel == 0) ? vcyc_a : vcyc_b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input int n);
        if (sel == 0) line_a = v; else line_b = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rdy(input int sel, input logic r);
        if (sel == 0) rdy_a = r; else rdy_b = r;
    endtask

    task automatic clear_obs(input int sel);
        if (sel == 0) obs_a.delete(); else obs_b.delete();
    endtask

    function automatic int obs_size(input int sel);
        return (sel == 0) ? obs_a.size() : obs_b.size();
    endfunction

    function automatic logic [10:0] obs_at(input int sel, input int i);
        return (sel == 0) ? obs_a[i] : obs_b[i];
    endfunction

    task automatic send_frame(input int sel, input logic [8:0] d, input logic pbit,
                              input logic [1:0] stops, input int idle);
        int nb;
        nb = (sel == 0) ? 8 : 7;
        drive(sel, 1'b0, CPB);
        for (int i = 0; i < nb; i++) drive(sel, d[i], CPB);
        if (sel == 1) drive(sel, pbit, CPB);
        drive(sel, stops[0], CPB);
        if (sel == 1) drive(sel, stops[1], CPB);
        drive(sel, 1'b1, idle);
    endtask

    task automatic check_reset(input int sel, input string tag);
        snap_t s;
        s = snap(sel);
        check({tag, "_data"}, 32'(s.d), 32'd0);
        check({tag, "_flags"}, 32'({s.v, s.dn, s.p, s.f, s.o, s.b}), 32'd0);
    endtask

    task automatic run_random(input int sel, input int n);
        logic [10:0] exp_q[$];
        logic        mv, movr;
        logic [10:0] mfr;
        snap_t       s;
        int          d0;
        mv = 1'b0; movr = 1'b0; mfr = '0;
        set_rdy(sel, 1'b1);
        drive(sel, 1'b1, 4);
        clear_obs(sel);
        for (int k = 0; k < n; k++) begin
            logic [8:0]  d;
            logic        fl, pb, r, pe, fe;
            logic [1:0]  st;
            logic [10:0] fr;
            d  = 9'($urandom_range(0, (sel == 0) ? 255 : 127));
            fl = ($urandom_range(0, 3) == 0);
            pb = (^d) ^ fl;
            st[0] = ($urandom_range(0, 5) != 0);
            st[1] = ($urandom_range(0, 5) != 0);
            pe = (sel == 1) ? fl : 1'b0;
            fe = (sel == 0) ? ~st[0] : ~(st[0] & st[1]);
            fr = {d, pe, fe};
            r  = ($urandom_range(0, 2) != 0);
            d0 = done_of(sel);
            set_rdy(sel, r);
            send_frame(sel, d, pb, st, 8);
            if (r) begin
                if (mv) exp_q.push_back(mfr);
                exp_q.push_back(fr);
                mv = 1'b0;
                movr = 1'b0;
            end else if (mv) begin
                movr = 1'b1;
            end else begin
                mv = 1'b1;
                mfr = fr;
            end
            s = snap(sel);
            check("rnd_done", 32'(done_of(sel) - d0), 32'd1);
            check("rnd_valid", 32'(s.v), 32'(mv));
            check("rnd_ovr", 32'(s.o), 32'(movr));
            if (mv) check("rnd_held", 32'({s.d, s.p, s.f}), 32'(mfr));
        end
        set_rdy(sel, 1'b1);
        drive(sel, 1'b1, 4);
        if (mv) exp_q.push_back(mfr);
        check("rnd_count", 32'(obs_size(sel)), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_size(sel); i++)
            check("rnd_frame", 32'(obs_at(sel, i)), 32'(exp_q[i]));
    endtask

    initial begin
        snap_t s;
        int d0, v0, bc;

        vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h037, 1'b1, 2'b11, 9'h037, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h037, 1'b0, 2'b11, 9'h037, 1'b1, 1'b0};
        vecs[3] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
        vecs[4] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h02A, 1'b1, 2'b10, 9'h02A, 1'b0, 1'b1};
        vecs[6] = '{1, 9'h07F, 1'b1, 2'b11, 9'h07F, 1'b0, 1'b0};
        vecs[7] = '{1, 9'h001, 1'b0, 2'b01, 9'h001, 1'b1, 1'b1};

        rstn_a = 1'b0; rstn_b = 1'b0;
        line_a = 1'b1; line_b = 1'b1;
        rdy_a = 1'b1; rdy_b = 1'b1;
        repeat (4) @(negedge clk);
        check_reset(0, "rst_a");
        check_reset(1, "rst_b");
        rstn_a = 1'b1; rstn_b = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            clear_obs(vecs[i].sel);
            d0 = done_of(vecs[i].sel);
            v0 = vcyc_of(vecs[i].sel);
            send_frame(vecs[i].sel, vecs[i].d, vecs[i].pbit, vecs[i].stops, 10);
            repeat (2) @(negedge clk);
            check("vec_count", 32'(obs_size(vecs[i].sel)), 32'd1);
            if (obs_size(vecs[i].sel) > 0) begin
                check("vec_data", 32'(obs_at(vecs[i].sel, 0) >> 2), 32'(vecs[i].exp_d));
                check("vec_perr", 32'(obs_at(vecs[i].sel, 0) >> 1 & 11'd1), 32'(vecs[i].exp_perr));
                check("vec_ferr", 32'(obs_at(vecs[i].sel, 0) & 11'd1), 32'(vecs[i].exp_ferr));
            end
            check("vec_done", 32'(done_of(vecs[i].sel) - d0), 32'd1);
            check("vec_vcyc", 32'(vcyc_of(vecs[i].sel) - v0), 32'd1);
            check("vec_ovr", 32'(snap(vecs[i].sel).o), 32'd0);
        end

        // Short low glitch on an idle line.
        d0 = done_a;
        bc = 0;
        line_a = 1'b0;
        repeat (2) @(negedge clk);
        line_a = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (a_busy === 1'b1) bc++;
        end
        check("glitch_busy_len", 32'(bc >= 1 && bc <= 6), 32'd1);
        check("glitch_busy_end", 32'(a_busy), 32'd0);
        check("glitch_done", 32'(done_a - d0), 32'd0);

        // Bad stop bit followed by a held-low break, then a clean frame.
        clear_obs(0);
        d0 = done_a;
        drive(0, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(0, (i % 2 == 0), CPB);
        drive(0, 1'b0, CPB + 60);
        drive(0, 1'b1, 10);
        check("brk_done", 32'(done_a - d0), 32'd1);
        check("brk_data", 32'(a_data), 32'h55);
        check("brk_ferr", 32'(a_ferr), 32'd1);
        check("brk_busy", 32'(a_busy), 32'd0);
        send_frame(0, 9'h03C, 1'b0, 2'b11, 10);
        check("brk_next_data", 32'(a_data), 32'h3C);
        check("brk_next_ferr", 32'(a_ferr), 32'd0);
        check("brk_total_done", 32'(done_a - d0), 32'd2);

        // Overrun: two frames with the consumer stalled.
        rdy_a = 1'b0;
        d0 = done_a;
        send_frame(0, 9'h011, 1'b0, 2'b11, 8);
        send_frame(0, 9'h022, 1'b0, 2'b11, 8);
        check("ovr_done", 32'(done_a - d0), 32'd2);
        check("ovr_valid", 32'(a_valid), 32'd1);
        check("ovr_data", 32'(a_data), 32'h11);
        check("ovr_flag", 32'(a_ovr), 32'd1);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        @(negedge clk);
        check("ovr_hs_valid", 32'(a_valid), 32'd0);
        check("ovr_hs_flag", 32'(a_ovr), 32'd0);
        check("ovr_hs_data", 32'(a_data), 32'h11);
        rdy_a = 1'b1;

        // Reset in the middle of data bit 4 of 0x0F.
        d0 = done_a;
        drive(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) drive(0, 1'b1, CPB);
        drive(0, 1'b0, 2);
        rstn_a = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0, "midrst");
        rstn_a = 1'b1;
        drive(0, 1'b0, 1 + 3 * CPB);
        drive(0, 1'b1, CPB + 20);
        check("midrst_done", 32'(done_a - d0), 32'd0);
        check("midrst_busy", 32'(a_busy), 32'd0);
        send_frame(0, 9'h0F0, 1'b0, 2'b11, 10);
        check("midrst_next", 32'(a_data), 32'hF0);
        check("midrst_next_done", 32'(done_a - d0), 32'd1);

        run_random(0, 25);
        run_random(1, 25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
